// File: rtl/matrix_unpack_stream_pkg.sv
`default_nettype none
// matrix_unpack_stream_pkg: shared FSM encoding and index-width helpers
// for the matrix element-stream blocks.
package matrix_unpack_stream_pkg;

  typedef enum logic {
    MU_IDLE   = 1'b0,
    MU_STREAM = 1'b1
  } mu_state_t;

  // Bits needed to hold a 1-based index up to n, with 0 as the reset value.
  function automatic int idx_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_index_counter.sv
`default_nettype none
// matrix_index_counter: 1-based 2D index walk over a ROWS x COLS matrix in
// row-major or column-major order, with end-of-line and end-of-matrix flags.
module matrix_index_counter
  import matrix_unpack_stream_pkg::*;
#(
  parameter int ROWS = 7,
  parameter int COLS = 7,
  localparam int IW = idx_w(max2(ROWS, COLS))
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          advance,
  input  logic          col_major,
  output logic [IW-1:0] row,
  output logic [IW-1:0] col,
  output logic          last_line,
  output logic          last
);

  localparam logic [IW-1:0] ROW_MAX = IW'(ROWS);
  localparam logic [IW-1:0] COL_MAX = IW'(COLS);
  localparam logic [IW-1:0] ONE     = IW'(1);

  logic cm;

  // Advancing past the final element is suppressed so the indices hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
      cm  <= 1'b0;
    end else if (load) begin
      row <= ONE;
      col <= ONE;
      cm  <= col_major;
    end else if (advance && !last) begin
      if (!cm) begin
        if (col == COL_MAX) begin
          col <= ONE;
          row <= row + ONE;
        end else begin
          col <= col + ONE;
        end
      end else begin
        if (row == ROW_MAX) begin
          row <= ONE;
          col <= col + ONE;
        end else begin
          row <= row + ONE;
        end
      end
    end
  end

  assign last_line = cm ? (row == ROW_MAX) : (col == COL_MAX);
  assign last      = (row == ROW_MAX) && (col == COL_MAX);

endmodule
`default_nettype wire

// File: rtl/matrix_unpack_stream.sv
`default_nettype none
// matrix_unpack_stream: captures one packed ROWS x COLS matrix and emits its
// elements one per cycle on a valid/ready stream with indices and flags.
module matrix_unpack_stream
  import matrix_unpack_stream_pkg::*;
#(
  parameter int bitlength = 8,
  parameter int ROWS      = 7,
  parameter int COLS      = 7,
  localparam int IW = idx_w(max2(ROWS, COLS))
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [ROWS*COLS*bitlength-1:0]  mat_in,
  input  logic                            mat_col_major,
  input  logic                            mat_valid,
  output logic                            mat_ready,
  output logic [bitlength-1:0]            elem_out,
  output logic [IW-1:0]                   elem_row,
  output logic [IW-1:0]                   elem_col,
  output logic                            elem_last_line,
  output logic                            elem_last,
  output logic                            elem_valid,
  input  logic                            elem_ready
);

  mu_state_t                         state;
  mu_state_t                         state_nxt;
  logic [ROWS*COLS*bitlength-1:0]    mat_q;
  logic                              armed;
  logic                              load;
  logic                              advance;

  // armed keeps mat_ready low on the reset edge itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= MU_IDLE;
      armed <= 1'b0;
      mat_q <= '0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      if (load) begin
        mat_q <= mat_in;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    case (state)
      MU_IDLE: begin
        if (mat_valid && armed) begin
          load      = 1'b1;
          state_nxt = MU_STREAM;
        end
      end
      MU_STREAM: begin
        if (elem_ready) begin
          advance = 1'b1;
          if (elem_last) begin
            state_nxt = MU_IDLE;
          end
        end
      end
    endcase
  end

  assign mat_ready  = (state == MU_IDLE) && armed;
  assign elem_valid = (state == MU_STREAM);

  matrix_index_counter #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_idx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .advance   (advance),
    .col_major (mat_col_major),
    .row       (elem_row),
    .col       (elem_col),
    .last_line (elem_last_line),
    .last      (elem_last)
  );

  // Index 0 (post-reset) selects nothing, so elem_out reads as zero.
  always_comb begin
    elem_out = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (elem_row == IW'(r + 1) && elem_col == IW'(c + 1)) begin
          elem_out = mat_q[(r*COLS + c)*bitlength +: bitlength];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/matrix_unpack_stream.md
# matrix_unpack_stream

Sequential reader for the packed 2D matrix bus produced by `MatrixAdd` and other matrix blocks. It accepts one packed ROWS×COLS matrix through a valid/ready handshake, registers it, and emits its elements one per cycle on a valid/ready element stream, with 1-based row/column indices and end-of-line/end-of-matrix flags. It sits between the matrix datapath and any element-serial consumer, such as an accumulator, an output port or a debug monitor.

## Interface
- `bitlength`, 8: element width in bits.
- `ROWS`, 7: matrix rows.
- `COLS`, 7: matrix columns.
- IW (derived), $clog2(max(ROWS,COLS)+1): index width.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `mat_in`  in  ROWS*COLS*bitlength  packed matrix. Element (i,j), 1-based, occupies bits [((i-1)*COLS+(j-1))*bitlength +: bitlength]. This is the PACK_2D_ARRAY/PORT_2D layout.
- `mat_col_major`  in  1  traversal order for this matrix, sampled on accept: 0 = row-major, 1 = column-major.
- `mat_valid`  in  1  `mat_in` and `mat_col_major` are valid.
- `mat_ready`  out  1  block can accept a matrix.
- `elem_out`  out  bitlength  current element value.
- `elem_row`  out  IW  1-based row index of `elem_out`.
- `elem_col`  out  IW  1-based column index of `elem_out`.
- `elem_last_line`  out  1  last element of the current row (row-major) or column (column-major).
- `elem_last`  out  1  last element of the matrix.
- `elem_valid`  out  1  element outputs are valid.
- `elem_ready`  in  1  consumer accepts the element.

## Operation
- The FSM has two states, IDLE and STREAM.
- IDLE:
  - `mat_ready`=1 and `elem_valid`=0.
  - On `mat_valid`&&`mat_ready` the block captures `mat_in` into its matrix register and latches `mat_col_major`.
  - It sets row=1, col=1 and moves to STREAM.
- STREAM:
  - `mat_ready`=0 and `elem_valid`=1.
  - `elem_out` is the captured element (`elem_row`, `elem_col`).
  - On `elem_ready`, the indices advance:
    - Row-major: col increments; at col=COLS, col returns to 1 and row increments.
    - Column-major: row increments; at row=ROWS, row returns to 1 and col increments.
- Flags:
  - `elem_last_line` is (col==COLS) in row-major and (row==ROWS) in column-major.
  - `elem_last` is (row==ROWS && col==COLS) in both orders.
- When the handshake completes with `elem_last`=1, the FSM returns to IDLE. Indices and `elem_out` hold their last values, and `elem_valid` drops.
- Backpressure: while `elem_valid`&&!`elem_ready`, every elem_* output holds stable.
- In STREAM, `mat_in`, `mat_valid` and `mat_col_major` are ignored. The captured matrix is not affected by later changes on `mat_in`.
- Degenerate sizes:
  - ROWS=1 or COLS=1 must work.
  - For a 1×1 matrix, the only element has `elem_last_line`=`elem_last`=1.
- There is no arithmetic. Values pass through unchanged, bit-exact.

## Timing
- Reset (rst_n low at a rising edge) sets:
  - state=IDLE
  - `mat_ready`=0, `elem_valid`=0
  - `elem_out`=0, `elem_row`=0, `elem_col`=0
  - `elem_last_line`=0, `elem_last`=0
  - matrix register=0
- `mat_ready` rises on the first rising edge with rst_n high.
- All outputs are registered, with no combinational input-to-output paths.
- Latency: a matrix accepted at edge N gives its first element valid after edge N.
- With `elem_ready` held high, element k (0-based) is presented after edge N+k. The last element handshakes at edge N+ROWS*COLS.
- After the final handshake, `mat_ready`=1 from that edge, so the next matrix can be accepted at the following edge.
- Throughput is ROWS*COLS+1 cycles per matrix: one bubble cycle.
- Reset asserted mid-STREAM discards the matrix. Outputs take their reset values after that edge, and no further elements are emitted.

## Structure
- PORT_2D, PACK_2D_ARRAY and UNPACK_2D_ARRAY stay in `config.v`, and the block uses them for `mat_in`.
- Add to `config.v`:
  - an IDX_W(n) macro for $clog2(n+1);
  - state encodings MU_IDLE=1'b0 and MU_STREAM=1'b1.
- Sub-module `matrix_index_counter`, parameters ROWS, COLS:
  - inputs: clk, rst_n, load, advance, col_major;
  - outputs: row, col, last_line, last.
  - It holds the 2D index walk for both orders and is reusable by a future `matrix_pack_stream` writer.
- The top level holds the FSM, the matrix register, the element mux and the output registers.

## Test plan
All scenarios use bitlength=8, ROWS=COLS=7, A[i][j]=2i+j.
- Row-major, `elem_ready` always 1:
  - 49 elements, in order (1,1)=3, (1,2)=4, …, (7,7)=21.
  - `elem_last_line` on every col=7.
  - `elem_last` only on (7,7).
  - `mat_ready` high again at the final handshake edge.
- Column-major, same matrix: order is (1,1)=3, (2,1)=5, …, (7,1)=15, (1,2)=4, and ends at (7,7)=21 with `elem_last`=1.
- Random `elem_ready` (50%) plus a 5-cycle stall at (3,4):
  - outputs hold value 10 and indices (3,4) throughout the stall;
  - no element is dropped or duplicated.
- Changing `mat_in` and pulsing `mat_valid` during STREAM:
  - `mat_ready` stays 0;
  - the output sequence is unchanged.
  - Back-to-back matrices A then B=A+1 are each streamed completely, with exactly one bubble cycle between them.
- Reset after the 20th element handshake:
  - after that edge `elem_valid`=0 and indices are 0;
  - `mat_ready`=1 one edge after rst_n deasserts;
  - a new matrix streams from (1,1).
- ROWS=1, COLS=3 build: 3 elements; every element has `elem_last_line`=1 in column-major order, and only the third has it in row-major order.
